// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle mul/div unit.
// Latches one op, pulses the unit, stalls, and emits one writeback.
module multdiv_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int EXC_MUL = 4,
  parameter int EXC_DIV = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_mul,
  input  logic              issue_div,
  input  logic [4:0]        issue_rd,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    WB
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              op_mul;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] res_q;
  logic              exc_q;
  logic              take;
  logic              hit_tmo;

  assign take    = (issue_mul | issue_div) & ~flush;
  assign hit_tmo = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (take) state_nx = START;
      START: state_nx = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)                   state_nx = IDLE;
        else if (md_ready | hit_tmo) state_nx = WB;
      end
      WB:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_mul      <= 1'b0;
      rd_q        <= '0;
      md_a        <= '0;
      md_b        <= '0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (take) begin
            md_a   <= issue_a;
            md_b   <= issue_b;
            rd_q   <= issue_rd;
            op_mul <= issue_mul;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // ready beats timeout when both land in the same cycle
          if (!flush) begin
            if (md_ready) begin
              res_q <= md_result;
              exc_q <= md_exception;
            end else if (hit_tmo) begin
              exc_q       <= 1'b1;
              timeout_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // IDLE stall is combinational so the issuing op freezes in its own cycle
  assign stall = (state == IDLE) ? (take & reset) : (state != WB);

  assign busy         = (state != IDLE);
  assign md_ctrl_mult = (state == START) &  op_mul;
  assign md_ctrl_div  = (state == START) & ~op_mul;

  always_comb begin
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    if (state == WB) begin
      if (exc_q) begin
        wb_valid = 1'b1;
        wb_reg   = 5'd30;
        wb_data  = op_mul ? DATA_W'(EXC_MUL) : DATA_W'(EXC_DIV);
      end else begin
        wb_valid = (rd_q != 5'd0);
        wb_reg   = rd_q;
        wb_data  = res_q;
      end
    end
  end

endmodule
